// File: rtl/scoreboard.sv
// In-order issue/commit scoreboard: circular buffer of in-flight instructions with writeback collection.
// Optional operand forwarding is built only when SB_FORWARD_EN is defined.
package ariane_pkg;
   localparam int unsigned NR_SB_ENTRIES = 4;
   localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
   localparam int unsigned NR_WB_PORTS   = 3;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception;

   typedef struct packed {
      logic [63:0]              pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [3:0]               fu;
      logic [7:0]               op;
      logic [4:0]               rs1;
      logic [4:0]               rs2;
      logic [4:0]               rd;
      logic [63:0]              result;
      logic                     valid;
      logic                     use_imm;
      exception                 ex;
   } scoreboard_entry;
endpackage

module scoreboard
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
   parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        flush_i,
   output logic                                        full_o,
   input  scoreboard_entry                             decoded_instr_i,
   input  logic                                        decoded_instr_valid_i,
   output logic                                        decoded_instr_ack_o,
   output logic [TRANS_ID_BITS-1:0]                    issued_trans_id_o,
   input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
   input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id_i,
   input  logic [NR_WB_PORTS-1:0][63:0]                wdata_i,
   input  exception [NR_WB_PORTS-1:0]                  ex_i,
   output scoreboard_entry                             commit_instr_o,
   output logic                                        commit_valid_o,
   input  logic                                        commit_ack_i,
   output logic [31:0]                                 rd_clobber_o,
   input  logic [4:0]                                  rs1_i,
   input  logic [4:0]                                  rs2_i,
   output logic [63:0]                                 rs1_o,
   output logic [63:0]                                 rs2_o,
   output logic                                        rs1_valid_o,
   output logic                                        rs2_valid_o
);
   localparam int unsigned TIDW = TRANS_ID_BITS;
   typedef logic [TIDW-1:0] tid_t;

   scoreboard_entry [NR_ENTRIES-1:0] mem_q, mem_d;
   logic [NR_ENTRIES-1:0]            occ_q, occ_d;
   tid_t                             head_q, head_d;
   tid_t                             tail_q, tail_d;
   logic [TIDW:0]                    cnt_q, cnt_d;
   logic                             issue_s;
   logic                             commit_s;

   // full depends only on the registered count, so a same-cycle commit never frees a slot for issue
   assign full_o              = (cnt_q == (TIDW+1)'(NR_ENTRIES));
   assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
   assign issue_s             = decoded_instr_ack_o;
   assign issued_trans_id_o   = tail_q;
   assign commit_instr_o      = mem_q[head_q];
   assign commit_valid_o      = occ_q[head_q] & mem_q[head_q].valid;
   assign commit_s            = commit_valid_o & commit_ack_i;

   // Next-state: flush dominates; otherwise writeback, commit and issue update the buffer
   always_comb begin
      mem_d  = mem_q;
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         occ_d  = '0;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
         for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            mem_d[i].valid = 1'b0;
         end
      end else begin
         // highest port first so the lowest-index port's write is the one that sticks
         for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
            if (wb_valid_i[p] && occ_q[trans_id_i[p]]) begin
               mem_d[trans_id_i[p]].result = wdata_i[p];
               mem_d[trans_id_i[p]].valid  = 1'b1;
               mem_d[trans_id_i[p]].ex     = ex_i[p];
            end else begin
               occ_d = occ_d;
            end
         end
         if (commit_s) begin
            occ_d[head_q]       = 1'b0;
            mem_d[head_q].valid = 1'b0;
            head_d              = head_q + tid_t'(1);
         end else begin
            head_d = head_q;
         end
         if (issue_s) begin
            mem_d[tail_q]          = decoded_instr_i;
            mem_d[tail_q].trans_id = tail_q;
            mem_d[tail_q].valid    = 1'b0;
            occ_d[tail_q]          = 1'b1;
            tail_d                 = tail_q + tid_t'(1);
         end else begin
            tail_d = tail_q;
         end
         case ({issue_s, commit_s})
            2'b10:   cnt_d = cnt_q + (TIDW+1)'(1);
            2'b01:   cnt_d = cnt_q - (TIDW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q  <= '0;
         occ_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Pending-writer map; x0 is never reported
   always_comb begin
      rd_clobber_o = '0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
         rd_clobber_o[mem_q[i].rd] = rd_clobber_o[mem_q[i].rd] | occ_q[i];
      end
      rd_clobber_o[0] = 1'b0;
   end

`ifdef SB_FORWARD_EN
   // Walk oldest to youngest from head so the youngest matching writer is the last one kept
   function automatic logic [64:0] fwd_lookup(
      input logic [4:0]                       rs,
      input scoreboard_entry [NR_ENTRIES-1:0] mem,
      input logic [NR_ENTRIES-1:0]            occ,
      input tid_t                             head
   );
      logic [64:0] hit;
      tid_t        idx;
      hit = 65'd0;
      for (int k = 0; k < int'(NR_ENTRIES); k++) begin
         idx = head + tid_t'(k);
         if (occ[idx] && (mem[idx].rd == rs)) begin
            hit = {mem[idx].valid & ~mem[idx].ex.valid, mem[idx].result};
         end else begin
            hit = hit;
         end
      end
      return ((rs == 5'd0) || !hit[64]) ? 65'd0 : hit;
   endfunction

   assign {rs1_valid_o, rs1_o} = fwd_lookup(rs1_i, mem_q, occ_q, head_q);
   assign {rs2_valid_o, rs2_o} = fwd_lookup(rs2_i, mem_q, occ_q, head_q);
`else
   logic unused_rs_s;
   assign unused_rs_s = ^{rs1_i, rs2_i};
   assign rs1_o       = 64'd0;
   assign rs2_o       = 64'd0;
   assign rs1_valid_o = 1'b0;
   assign rs2_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_scoreboard.sv
// Directed and randomized bench for the scoreboard, checked against a queue-based in-order model.
module tb_scoreboard;
   import ariane_pkg::*;

   localparam int NR = 4;
   localparam int NP = 3;

   logic                  clk = 1'b0;
   logic                  rst_ni;
   logic                  flush;
   logic                  full;
   scoreboard_entry       din;
   logic                  din_v;
   logic                  ack;
   logic [1:0]            issued_id;
   logic [NP-1:0]         wb_v;
   logic [NP-1:0][1:0]    wb_id;
   logic [NP-1:0][63:0]   wb_data;
   exception [NP-1:0]     wb_ex;
   scoreboard_entry       cinstr;
   logic                  cvalid;
   logic                  cack;
   logic [31:0]           clobber;
   logic [4:0]            rs1, rs2;
   logic [63:0]           rs1_o, rs2_o;
   logic                  rs1_v, rs2_v;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int          id;
      logic [4:0]  rd;
      logic [63:0] pc;
      logic [63:0] res;
      bit          v;
      bit          exv;
   } ment_t;
   ment_t q[$];
   int    next_id = 0;

   scoreboard dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .full_o(full),
      .decoded_instr_i(din), .decoded_instr_valid_i(din_v), .decoded_instr_ack_o(ack),
      .issued_trans_id_o(issued_id), .wb_valid_i(wb_v), .trans_id_i(wb_id),
      .wdata_i(wb_data), .ex_i(wb_ex), .commit_instr_o(cinstr), .commit_valid_o(cvalid),
      .commit_ack_i(cack), .rd_clobber_o(clobber), .rs1_i(rs1), .rs2_i(rs2),
      .rs1_o(rs1_o), .rs2_o(rs2_o), .rs1_valid_o(rs1_v), .rs2_valid_o(rs2_v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_clobber();
      logic [31:0] c = 32'd0;
      foreach (q[i]) c[q[i].rd] = 1'b1;
      c[0] = 1'b0;
      return c;
   endfunction

   function automatic logic [64:0] exp_fwd(input logic [4:0] rs);
`ifdef SB_FORWARD_EN
      if (rs == 5'd0) return 65'd0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].rd == rs) return (q[i].v && !q[i].exv) ? {1'b1, q[i].res} : 65'd0;
      end
      return 65'd0;
`else
      return 65'd0;
`endif
   endfunction

   task automatic check_outputs();
      logic [64:0] f1, f2;
      bit          ef;
      ef = (q.size() == NR);
      chk("full", full, ef);
      chk("ack", ack, din_v && !ef && !flush);
      chk("issued_id", issued_id, next_id);
      chk("commit_valid", cvalid, (q.size() > 0) && q[0].v);
      if (q.size() > 0) begin
         chk("head_id", cinstr.trans_id, q[0].id);
         chk("head_rd", cinstr.rd, q[0].rd);
         chk("head_pc", cinstr.pc, q[0].pc);
         chk("head_result", cinstr.result, q[0].res);
         chk("head_valid", cinstr.valid, q[0].v);
         chk("head_exv", cinstr.ex.valid, q[0].exv);
      end
      chk("clobber", clobber, exp_clobber());
      f1 = exp_fwd(rs1);
      f2 = exp_fwd(rs2);
      chk("rs1_valid", rs1_v, f1[64]);
      chk("rs2_valid", rs2_v, f2[64]);
      if (f1[64]) chk("rs1_data", rs1_o, f1[63:0]);
      if (f2[64]) chk("rs2_data", rs2_o, f2[63:0]);
   endtask

   task automatic model_update();
      bit    commit_now, issue_now;
      bit    written [NR];
      ment_t e;
      commit_now = (q.size() > 0) && q[0].v && cack;
      issue_now  = din_v && (q.size() < NR) && !flush;
      if (flush) begin
         q.delete();
         next_id = 0;
         return;
      end
      for (int i = 0; i < NR; i++) written[i] = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (wb_v[p] && !written[wb_id[p]]) begin
            written[wb_id[p]] = 1'b1;
            for (int i = 0; i < q.size(); i++) begin
               if (q[i].id == int'(wb_id[p])) begin
                  e = q[i]; e.res = wb_data[p]; e.v = 1'b1; e.exv = wb_ex[p].valid; q[i] = e;
               end
            end
         end
      end
      if (commit_now) void'(q.pop_front());
      if (issue_now) begin
         e.id = next_id; e.rd = din.rd; e.pc = din.pc; e.res = din.result;
         e.v = 1'b0; e.exv = din.ex.valid;
         q.push_back(e);
         next_id = (next_id + 1) % NR;
      end
   endtask

   task automatic tick();
      #1;
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      din = '0; din_v = 1'b0; wb_v = '0; wb_id = '0; wb_data = '0; wb_ex = '0;
      cack = 1'b0; flush = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [63:0] imm);
      din = '0; din.rd = rd; din.result = imm; din.pc = 64'h1000 + 64'(rd);
      din.trans_id = 2'b11; din.valid = 1'b1; din_v = 1'b1;
      tick();
      din_v = 1'b0;
   endtask

   task automatic do_wb(input int port, input logic [1:0] id, input logic [63:0] data);
      wb_v = '0; wb_v[port] = 1'b1; wb_id[port] = id; wb_data[port] = data;
      tick();
      wb_v = '0;
   endtask

   task automatic rand_inputs();
      din = '0;
      din.pc = {$urandom, $urandom}; din.rd = 5'($urandom_range(0, 7));
      din.result = {$urandom, $urandom}; din.op = 8'($urandom);
      din.trans_id = 2'($urandom); din.valid = 1'($urandom);
      din_v = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++) begin
         wb_v[p] = ($urandom_range(0, 2) == 0); wb_id[p] = 2'($urandom);
         wb_data[p] = {$urandom, $urandom}; wb_ex[p] = '0;
         wb_ex[p].valid = ($urandom_range(0, 7) == 0); wb_ex[p].cause = {$urandom, $urandom};
      end
      cack = 1'($urandom); flush = ($urandom_range(0, 39) == 0);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
   endtask

   initial begin
      // reset state
      rst_ni = 1'b0;
      idle();
      #3;
      chk("rst_full", full, 1'b0);
      chk("rst_commit_valid", cvalid, 1'b0);
      chk("rst_issued_id", issued_id, 2'd0);
      chk("rst_clobber", clobber, 32'd0);
      chk("rst_rs1_valid", rs1_v, 1'b0);
      chk("rst_rs1_data", rs1_o, 64'd0);
      n_assert++;
      assert (cinstr === '0) else begin
         n_fail++;
         $error("FAIL rst_commit_instr: observed %0h expected 0", cinstr);
      end
      @(posedge clk); #1;
      rst_ni = 1'b1;
      @(posedge clk); #1;

      // fill: ids 0..3, full, clobber 0x1E, 5th rejected
      for (int r = 1; r <= 4; r++) begin
         #1; chk("fill_id", issued_id, 64'(r - 1));
         do_issue(5'(r), 64'(r) << 8);
      end
      #1;
      chk("fill_full", full, 1'b1);
      chk("fill_clobber", clobber, 32'h1E);
      din_v = 1'b1;
      #1; chk("fifth_ack", ack, 1'b0);
      tick();
      din_v = 1'b0;

      // out-of-order writeback: head waits for id 0
      do_wb(0, 2'd2, 64'hAA);
      #1; chk("wait_id0", cvalid, 1'b0);
      do_wb(1, 2'd0, 64'h55);
      #1; chk("id0_ready", cvalid, 1'b1);
      chk("id0_result", cinstr.result, 64'h55);

      // issue and commit together while full: issue refused
      din = '0; din.rd = 5'd9; din_v = 1'b1; cack = 1'b1;
      #1; chk("full_issue_ack", ack, 1'b0);
      tick();
      idle();
      #1; chk("after_pop_full", full, 1'b0);
      chk("head_waits_id1", cvalid, 1'b0);
      chk("head_is_id1", cinstr.trans_id, 2'd1);
      chk("wrap_id", issued_id, 2'd0);
      do_issue(5'd6, 64'h6);

      // two ports hit id 1: port 0 wins
      wb_v = 3'b101; wb_id[0] = 2'd1; wb_id[2] = 2'd1; wb_data[0] = 64'h11; wb_data[2] = 64'h22;
      tick();
      idle();
      #1; chk("dual_wb_result", cinstr.result, 64'h11);
      cack = 1'b1; tick(); tick(); cack = 1'b0;

      // forwarding from the youngest of two writers of x5
      flush = 1'b1; tick(); flush = 1'b0;
      do_issue(5'd5, 64'h1);
      do_issue(5'd5, 64'h2);
      do_wb(0, 2'd1, 64'h77);
      rs1 = 5'd5;
      #1;
`ifdef SB_FORWARD_EN
      chk("fwd_x5_valid", rs1_v, 1'b1);
      chk("fwd_x5_data", rs1_o, 64'h77);
`else
      chk("fwd_x5_valid", rs1_v, 1'b0);
`endif
      rs1 = 5'd0;
      #1; chk("fwd_x0_valid", rs1_v, 1'b0);

      // flush beats simultaneous issue, writeback and commit
      do_issue(5'd7, 64'h3);
      do_wb(0, 2'd0, 64'h5);
      din = '0; din.rd = 5'd9; din_v = 1'b1;
      wb_v = 3'b001; wb_id[0] = 2'd2; wb_data[0] = 64'h99;
      cack = 1'b1; flush = 1'b1;
      tick();
      idle();
      #1;
      chk("flush_full", full, 1'b0);
      chk("flush_commit_valid", cvalid, 1'b0);
      chk("flush_clobber", clobber, 32'd0);
      chk("flush_next_id", issued_id, 2'd0);
      do_issue(5'd3, 64'h4);

      // random traffic
      for (int c = 0; c < 400; c++) begin
         rand_inputs();
         tick();
      end

      // asynchronous reset mid-operation
      idle();
      for (int c = 0; c < 3; c++) do_issue(5'(c + 1), 64'(c));
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_rst_full", full, 1'b0);
      chk("async_rst_clobber", clobber, 32'd0);
      chk("async_rst_commit_valid", cvalid, 1'b0);
      chk("async_rst_issued_id", issued_id, 2'd0);
      q.delete();
      next_id = 0;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      @(posedge clk); #1;

      for (int c = 0; c < 200; c++) begin
         rand_inputs();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
